// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures execute results, holds on memory stall,
// squashes flushed instructions, and freezes on halt or memory error.
module ex_mem_reg #(
    parameter int DW = 16,
    parameter int RW = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          MemStall,
    input  logic          MemErr,
    input  logic          flush,

    input  logic          ex_valid,
    input  logic [DW-1:0] ex_ALUData,
    input  logic [DW-1:0] ex_wdata,
    input  logic [DW-1:0] ex_PCData,
    input  logic          ex_MemRead,
    input  logic          ex_MemWrite,
    input  logic          ex_WriteDataPC,
    input  logic          ex_WriteDataMem,
    input  logic          ex_RegWrite,
    input  logic          ex_halt,
    input  logic [RW-1:0] ex_WriteReg,

    output logic [DW-1:0] mem_ALUData,
    output logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_PCData,
    output logic          mem_MemRead,
    output logic          mem_MemWrite,
    output logic          mem_WriteDataPC,
    output logic          mem_WriteDataMem,
    output logic          mem_RegWrite,
    output logic          mem_halt,
    output logic [RW-1:0] mem_WriteReg,

    output logic          mem_valid,
    output logic          mem_createdump,
    output logic          stall_ex,
    output logic          err,
    output logic [CW-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2,
        ERROR  = 2'd3
    } state_e;

    typedef struct packed {
        logic [DW-1:0] alu_data;
        logic [DW-1:0] wdata;
        logic [DW-1:0] pc_data;
        logic [RW-1:0] write_reg;
        logic          mem_read;
        logic          mem_write;
        logic          write_data_pc;
        logic          write_data_mem;
        logic          reg_write;
        logic          halt;
    } payload_t;

    state_e          state_q, state_d;
    payload_t        payload_q, payload_d;
    payload_t        ex_payload;
    logic            valid_q, valid_d;
    logic            dump_q, dump_d;
    logic            err_q, err_d;
    logic            flush_pending_q, flush_pending_d;
    logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
    logic            load_valid;

    always_comb begin
        ex_payload.alu_data       = ex_ALUData;
        ex_payload.wdata          = ex_wdata;
        ex_payload.pc_data        = ex_PCData;
        ex_payload.write_reg      = ex_WriteReg;
        ex_payload.mem_read       = ex_MemRead;
        ex_payload.mem_write      = ex_MemWrite;
        ex_payload.write_data_pc  = ex_WriteDataPC;
        ex_payload.write_data_mem = ex_WriteDataMem;
        ex_payload.reg_write      = ex_RegWrite;
        ex_payload.halt           = ex_halt;
    end

    // NOTE: every _d gets a hold default before any branch, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        payload_d       = payload_q;
        valid_d         = valid_q;
        dump_d          = 1'b0;
        err_d           = err_q;
        flush_pending_d = flush_pending_q;
        stall_cnt_d     = stall_cnt_q;
        load_valid      = ex_valid & ~flush & ~flush_pending_q;

        case (state_q)
            RUN, HOLD: begin
                if (MemStall && (stall_cnt_q != {CW{1'b1}})) begin
                    stall_cnt_d = stall_cnt_q + CW'(1);
                end

                if (MemErr && valid_q) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else if (MemStall) begin
                    // A flush seen during a stall applies to the instruction loaded afterwards.
                    flush_pending_d = flush_pending_q | flush;
                    state_d         = HOLD;
                end else begin
                    payload_d       = ex_payload;
                    valid_d         = load_valid;
                    flush_pending_d = 1'b0;
                    dump_d          = ex_halt & load_valid;
                    state_d         = (ex_halt & load_valid) ? HALTED : RUN;
                end
            end
            default: begin
                // HALTED and ERROR are terminal until reset.
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= RUN;
            payload_q       <= '0;
            valid_q         <= 1'b0;
            dump_q          <= 1'b0;
            err_q           <= 1'b0;
            flush_pending_q <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            payload_q       <= payload_d;
            valid_q         <= valid_d;
            dump_q          <= dump_d;
            err_q           <= err_d;
            flush_pending_q <= flush_pending_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    // Side-effecting controls are masked so a bubble never touches memory or the register file.
    assign mem_ALUData      = payload_q.alu_data;
    assign mem_wdata        = payload_q.wdata;
    assign mem_PCData       = payload_q.pc_data;
    assign mem_WriteReg     = payload_q.write_reg;
    assign mem_MemRead      = payload_q.mem_read  & valid_q;
    assign mem_MemWrite     = payload_q.mem_write & valid_q;
    assign mem_RegWrite     = payload_q.reg_write & valid_q;
    assign mem_WriteDataPC  = payload_q.write_data_pc;
    assign mem_WriteDataMem = payload_q.write_data_mem;
    assign mem_halt         = payload_q.halt;

    assign mem_valid      = valid_q;
    assign mem_createdump = dump_q;
    assign err            = err_q;
    assign stall_cycles   = stall_cnt_q;
    assign stall_ex       = MemStall | (state_q == HALTED) | (state_q == ERROR);

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the execute stage and the memory stage.
- Captures the execute-stage results and controls, then presents them to the memory stage for one or more cycles.
- Holds its contents while the memory stage reports a stall, and turns flushed instructions into bubbles.
- Freezes the pipeline on a memory error or a halt instruction.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DW, 16, data/address width
- RW, 3, register-specifier width
- CW, 16, stall-counter width

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-low reset; sampled on the rising edge of clk.
- MemStall  in  1  Memory stage busy; hold current contents.
- MemErr  in  1  Memory stage error for the held instruction.
- flush  in  1  Squash the instruction currently presented by execute.
- ex_valid  in  1  Execute output holds a real instruction.
- ex_ALUData  in  DW  ALU result / memory address.
- ex_wdata  in  DW  Store data.
- ex_PCData  in  DW  PC+2 for link writes.
- ex_MemRead, ex_MemWrite, ex_WriteDataPC, ex_WriteDataMem, ex_RegWrite, ex_halt  in  1 each  Decoded controls.
- ex_WriteReg  in  RW  Destination register.
- mem_* (one per ex_* data/control above)  out  same widths  Registered copies fed to the memory stage.
- mem_valid  out  1  Registered valid.
- mem_createdump  out  1  Pulses 1 cycle when a valid halt is captured.
- stall_ex  out  1  Back-pressure to upstream stages; combinational: MemStall | halted | errored.
- err  out  1  Sticky memory error.
- stall_cycles  out  CW  Saturating count of MemStall cycles.

Behaviour:
- Reset (rst==0 at posedge):
  - All mem_* outputs, mem_valid, mem_createdump, err and stall_cycles go to 0.
  - flush_pending goes to 0; state goes to RUN.
  - Reset overrides every other input, including a reset asserted mid-stall.
- Gating: mem_MemRead, mem_MemWrite and mem_RegWrite are the registered value AND mem_valid, so a bubble never accesses memory or writes the register file.
- States:
  - RUN: load every cycle.
  - HOLD: MemStall high, contents frozen.
  - HALTED: valid halt captured; no further loads.
  - ERROR: err set; no further loads.
- Per-edge priority (rst high): ERROR/HALTED hold > MemErr > MemStall > flush > load.
  - MemErr=1 while mem_valid=1 (any non-terminal state): set err, go to ERROR, contents held. err clears only on reset.
  - MemStall=1: hold all registers, go to HOLD. A flush arriving now sets flush_pending instead of acting.
  - MemStall=0 from HOLD: return to RUN and load this cycle.
  - Load: mem_* <= ex_*, and mem_valid <= ex_valid & ~flush & ~flush_pending. flush_pending then clears.
  - Loaded valid halt (ex_halt & resulting mem_valid): mem_createdump=1 for exactly that cycle, then state goes to HALTED. A flushed halt does not halt.
- Latency: 1 cycle from ex_* to mem_* when not stalled. Data fields also load when the instruction is squashed (values are don't-care, but deterministic).
- stall_cycles: +1 on every edge with MemStall=1 and state RUN/HOLD. Saturates at 2^CW-1 (no wrap). Frozen in HALTED/ERROR.
- Simultaneous events:
  - MemStall & MemErr together: MemErr wins.
  - flush & MemStall together: defer the flush via flush_pending.
  - Halt captured while MemStall is high on the following cycle: HALTED still entered, contents held.

Test Plan:
- Reset: hold rst=0 for 2 cycles with ex_valid=1 and ex_ALUData=16'h1234 → mem_valid=0, mem_ALUData=0, stall_cycles=0, err=0. Release rst → next edge mem_ALUData=16'h1234, mem_valid=1.
- Stall hold: load a store (addr 16'h0040, data 16'hBEEF), then MemStall=1 for 3 cycles while ex_* changes → mem_* stays 0040/BEEF and mem_MemWrite=1 for all 3 cycles. stall_cycles=3. The new ex_* is loaded on the edge after MemStall falls.
- Flush: flush=1 with ex_MemWrite=1 → mem_valid=0 and mem_MemWrite=0 next cycle. Flush during MemStall → the instruction loaded after the stall has mem_valid=0.
- Halt: valid ex_halt → mem_createdump high exactly 1 cycle. stall_ex=1 afterwards, and ex_* changes no longer load.
- Error: MemErr=1 together with MemStall=1 → err=1 next edge and stays 1. Contents frozen; stall_cycles stops incrementing. Only rst=0 clears it.
- Saturation: CW=4, hold MemStall for 20 cycles → stall_cycles=4'hF.
